// File: rtl/cookie_sched.sv
// Cookie scheduler: round-robin cookie grants, periodic cookie rotation, cookie checks (COOKIE_PREV_EN keeps the previous-epoch cookie valid for checks).
// Latency: req sampled in RUN -> gnt/c_val/c_epoch next cycle; chk_valid -> chk_done/chk_hit next cycle.
// Backpressure: none; req is a held level until granted, and no grants are issued in INIT/ROTATE.
module cookie_sched #(
  parameter int          NUM_REQ     = 4,
  parameter int          ROT_PERIOD  = 1024,
  parameter logic [31:0] COOKIE_BASE = 32'hf1ec234d
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [95:0]        time_stamp,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [31:0]        c_val,
  output logic               c_epoch,
  input  logic               chk_valid,
  input  logic [31:0]        chk_cookie,
  output logic               chk_done,
  output logic               chk_hit
);

  localparam int CW = $clog2(ROT_PERIOD);
  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_ROTATE} state_t;

  state_t        state, next_state;
  logic [31:0]   cur;
  logic          epoch;
  logic [CW-1:0] cnt;
  logic [PW-1:0] ptr;
  logic [PW-1:0] pick_idx;
  logic          pick_vld;
  logic [PW:0]   idx_w;
  logic          rot_hit;
  logic          chk_match;
  logic [31:0]   ts_lo;
  logic          unused_ts;

  assign ts_lo     = time_stamp[31:0];
  assign unused_ts = ^time_stamp[95:32];
  assign rot_hit   = (cnt == CW'(ROT_PERIOD - 1));

  function automatic logic [31:0] mix(input logic [31:0] x, input logic [31:0] ts);
    return x ^ (ts >> 16) ^ ts;
  endfunction

  always_ff @(posedge clk) begin
    if (rst_n) state <= ST_INIT;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_INIT:   next_state = ST_RUN;
      ST_RUN:    if (rot_hit) next_state = ST_ROTATE;
      ST_ROTATE: next_state = ST_RUN;
      default:   next_state = ST_INIT;
    endcase
  end

  // Search starts one past the last winner and wraps, so every requester is reached within NUM_REQ grants.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    idx_w    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx_w = {1'b0, ptr} + (PW+1)'(i);
      if (idx_w >= (PW+1)'(NUM_REQ)) idx_w = idx_w - (PW+1)'(NUM_REQ);
      if (!pick_vld && req[idx_w[PW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = idx_w[PW-1:0];
      end
    end
  end

`ifdef COOKIE_PREV_EN
  logic [31:0] prev;
  logic        prev_valid;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (state == ST_ROTATE) begin
      prev       <= cur;
      prev_valid <= 1'b1;
    end
  end

  assign chk_match = (chk_cookie == cur) || (prev_valid && (chk_cookie == prev));
`else
  assign chk_match = (chk_cookie == cur);
`endif

  always_ff @(posedge clk) begin
    if (rst_n) begin
      cur      <= COOKIE_BASE;
      epoch    <= 1'b0;
      cnt      <= '0;
      ptr      <= PW'(NUM_REQ - 1);
      gnt      <= '0;
      c_val    <= '0;
      c_epoch  <= 1'b0;
      chk_done <= 1'b0;
      chk_hit  <= 1'b0;
    end else begin
      gnt      <= '0;
      chk_done <= chk_valid;
      chk_hit  <= chk_valid && chk_match;
      case (state)
        ST_INIT: begin
          cur <= mix(cur, ts_lo);
          cnt <= '0;
        end
        ST_RUN: begin
          cnt <= cnt + CW'(1);
          if (pick_vld) begin
            gnt     <= NUM_REQ'(1) << pick_idx;
            c_val   <= cur;
            c_epoch <= epoch;
            ptr     <= pick_idx;
          end
        end
        ST_ROTATE: begin
          cur   <= mix(cur, ts_lo);
          epoch <= ~epoch;
          cnt   <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cookie_sched.sv
// Bench for cookie_sched with ROT_PERIOD=16 and a constant timestamp; grant and check results are scoreboarded.
module tb_cookie_sched;

  localparam int          NREQ = 4;
  localparam int          RP   = 16;
  localparam logic [31:0] BASE = 32'hf1ec234d;
  localparam logic [31:0] C1   = 32'hf1ed234e;
`ifdef COOKIE_PREV_EN
  localparam logic PREV_HIT = 1'b1;
`else
  localparam logic PREV_HIT = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [95:0]     time_stamp;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [31:0]     c_val;
  logic            c_epoch;
  logic            chk_valid;
  logic [31:0]     chk_cookie;
  logic            chk_done;
  logic            chk_hit;

  always #5 clk = ~clk;

  cookie_sched #(.NUM_REQ(NREQ), .ROT_PERIOD(RP), .COOKIE_BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .time_stamp(time_stamp), .req(req), .gnt(gnt),
    .c_val(c_val), .c_epoch(c_epoch), .chk_valid(chk_valid), .chk_cookie(chk_cookie),
    .chk_done(chk_done), .chk_hit(chk_hit)
  );

  typedef struct packed {
    logic [3:0]  gnt;
    logic [31:0] val;
    logic        epoch;
  } gexp_t;

  typedef struct {
    logic [31:0] cookie;
    logic        hit;
  } chk_vec_t;

  gexp_t    gq[$];
  logic     hq[$];
  chk_vec_t vecs[5];
  logic [3:0] rr_exp[3];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: sample outputs just after the edge, score them, and let requesters drop granted bits.
  task automatic step();
    gexp_t e;
    @(posedge clk);
    #1;
    if (gnt !== '0) begin
      check("gnt_onehot", {31'b0, $onehot(gnt)}, 32'd1);
      if (gq.size() == 0) check("gnt_unexpected", {28'b0, gnt}, 32'd0);
      else begin
        e = gq.pop_front();
        check("gnt_val", {28'b0, gnt}, {28'b0, e.gnt});
        check("c_val", c_val, e.val);
        check("c_epoch", {31'b0, c_epoch}, {31'b0, e.epoch});
      end
      req = req & ~gnt;
    end
    if (chk_done === 1'b1) begin
      if (hq.size() == 0) check("chk_unexpected", {31'b0, chk_done}, 32'd0);
      else check("chk_hit", {31'b0, chk_hit}, {31'b0, hq.pop_front()});
    end
  endtask

  task automatic drive_chk(input logic [31:0] c, input logic h);
    chk_valid  = 1'b1;
    chk_cookie = c;
    hq.push_back(h);
  endtask

  initial begin
    vecs[0] = '{BASE, 1'b1};
    vecs[1] = '{C1, PREV_HIT};
    vecs[2] = '{32'hdeadbeef, 1'b0};
    vecs[3] = '{32'hf1ec234c, 1'b0};
    vecs[4] = '{32'h00000000, 1'b0};
    rr_exp[0] = 4'b1000;
    rr_exp[1] = 4'b0001;
    rr_exp[2] = 4'b0010;

    rst_n      = 1'b1;
    req        = '0;
    chk_valid  = 1'b0;
    chk_cookie = '0;
    time_stamp = {32'h12345678, 32'h9abcdef0, 32'h00010002};
    repeat (3) step();
    check("rst_gnt", {28'b0, gnt}, 32'd0);
    check("rst_c_val", c_val, 32'd0);
    check("rst_c_epoch", {31'b0, c_epoch}, 32'd0);
    check("rst_chk_done", {31'b0, chk_done}, 32'd0);
    check("rst_chk_hit", {31'b0, chk_hit}, 32'd0);

    // INIT cycle: requests stay pending, the check sees the seed cookie
    rst_n = 1'b0;
    req   = 4'b1111;
    drive_chk(BASE, 1'b1);
    for (int k = 0; k < 4; k++) gq.push_back('{gnt: 4'(1 << k), val: C1, epoch: 1'b0});
    step();
    check("init_no_gnt", {28'b0, gnt}, 32'd0);
    check("init_chk_done", {31'b0, chk_done}, 32'd1);
    chk_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("rr_seq", {28'b0, gnt}, {28'b0, 4'(1 << k)});
    end

    repeat (10) step();
    drive_chk(C1, 1'b1);
    step();
    chk_valid = 1'b0;
    step();
    check("last_run_no_gnt", {28'b0, gnt}, 32'd0);

    // ROTATE cycle: request waits for RUN, check uses the pre-rotation cookie
    req = 4'b0100;
    gq.push_back('{gnt: 4'b0100, val: BASE, epoch: 1'b1});
    drive_chk(C1, 1'b1);
    step();
    check("rotate_no_gnt", {28'b0, gnt}, 32'd0);
    check("rotate_chk_done", {31'b0, chk_done}, 32'd1);

    for (int i = 0; i < 5; i++) begin
      drive_chk(vecs[i].cookie, vecs[i].hit);
      step();
      check("chk_b2b_done", {31'b0, chk_done}, 32'd1);
      if (i == 0) check("gnt_after_rotate", {28'b0, gnt}, 32'h4);
    end
    chk_valid = 1'b0;
    step();
    check("chk_idle", {31'b0, chk_done}, 32'd0);

    // Pointer is at 2: wrap order 3,0,1
    req = 4'b1011;
    for (int k = 0; k < 3; k++) gq.push_back('{gnt: rr_exp[k], val: BASE, epoch: 1'b1});
    for (int k = 0; k < 3; k++) begin
      step();
      check("rr_wrap", {28'b0, gnt}, {28'b0, rr_exp[k]});
    end
    step();
    check("hold_gnt", {28'b0, gnt}, 32'd0);
    check("hold_c_val", c_val, BASE);
    check("hold_c_epoch", {31'b0, c_epoch}, 32'd1);

    // Reset mid-operation with a request and a check pending
    req        = 4'b0001;
    chk_valid  = 1'b1;
    chk_cookie = BASE;
    rst_n      = 1'b1;
    step();
    check("midrst_gnt", {28'b0, gnt}, 32'd0);
    check("midrst_chk_done", {31'b0, chk_done}, 32'd0);
    check("midrst_c_val", c_val, 32'd0);
    check("midrst_c_epoch", {31'b0, c_epoch}, 32'd0);

    rst_n = 1'b0;
    req   = 4'b1001;
    drive_chk(BASE, 1'b1);
    gq.push_back('{gnt: 4'b0001, val: C1, epoch: 1'b0});
    gq.push_back('{gnt: 4'b1000, val: C1, epoch: 1'b0});
    step();
    check("init2_chk_done", {31'b0, chk_done}, 32'd1);
    chk_valid = 1'b0;
    step();
    check("ptr_reset", {28'b0, gnt}, 32'h1);
    step();
    check("ptr_reset2", {28'b0, gnt}, 32'h8);
    step();

    check("gq_empty", gq.size(), 32'd0);
    check("hq_empty", hq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
